// File: rtl/path_count_walker.sv
// Depth-first path counter over the decoded DAG: pops nodes from an on-chip
// stack, queries the adjacency map for each, and pushes every returned edge.
module path_count_walker #(
  parameter int MAX_NODES   = 1024,
  parameter int NODE_WIDTH  = $clog2(MAX_NODES),
  parameter int STACK_DEPTH = 512,
  parameter int COUNT_WIDTH = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NODE_WIDTH-1:0]  start_node,
  input  logic [NODE_WIDTH-1:0]  target_node,
  input  logic                   query_ready,
  output logic                   query_valid,
  output logic [NODE_WIDTH-1:0]  query_data,
  output logic                   reply_ready,
  input  logic                   reply_valid,
  input  logic [NODE_WIDTH-1:0]  reply_data,
  input  logic                   reply_last,
  input  logic                   reply_no_edges_found,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] path_count,
  output logic                   stack_overflow
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_QUERY   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SP_W-1:0]        sp_q;
  logic [NODE_WIDTH-1:0]  cur_q;
  logic [NODE_WIDTH-1:0]  target_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   ovf_q;
  logic                   done_q;
  logic                   ready_raw;

  logic [NODE_WIDTH-1:0]  stack_mem [STACK_DEPTH];
  logic [IDX_W-1:0]       mem_addr;
  logic [NODE_WIDTH-1:0]  mem_rd;
  logic                   mem_we;
  logic [NODE_WIDTH-1:0]  mem_wd;

  logic                   stack_empty;
  logic                   stack_full;
  logic                   beat;
  logic                   push_req;
  logic                   push_en;
  logic                   target_hit;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign beat        = reply_valid && reply_ready;
  assign push_req    = (state_q == ST_COLLECT) && beat && !reply_no_edges_found;
  assign push_en     = push_req && !stack_full;

  // Single address port: the top entry is read in POP, writes happen in IDLE
  // (root seed at index 0) and COLLECT (push at sp); these never overlap.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = reply_data;
    if (state_q == ST_POP) begin
      mem_addr = IDX_W'(sp_q - SP_W'(1));
    end else if (state_q == ST_IDLE) begin
      mem_we   = start;
      mem_wd   = start_node;
    end else begin
      mem_addr = IDX_W'(sp_q);
      mem_we   = push_en;
    end
  end

  assign mem_rd     = stack_mem[mem_addr];
  assign target_hit = (mem_rd == target_q);

  always_ff @(posedge clk) begin
    if (mem_we) stack_mem[mem_addr] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) target_q <= target_node;
  end

  always_comb begin
    state_d     = state_q;
    query_valid = 1'b0;
    ready_raw   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (start) state_d = ST_POP;
      end
      ST_POP: begin
        busy = 1'b1;
        if (stack_empty)     state_d = ST_DONE;
        else if (target_hit) state_d = ST_POP;
        else                 state_d = ST_QUERY;
      end
      ST_QUERY: begin
        busy = 1'b1;
        // The responder latches its index on query_valid alone, so the strobe
        // is only raised in a cycle where it is guaranteed to be taken.
        query_valid = query_ready;
        if (query_ready) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        busy      = 1'b1;
        ready_raw = 1'b1;
        if (beat && reply_last) state_d = ST_POP;
      end
      ST_DONE: begin
        ready_raw = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stray beats are drained outside a traversal, but not while reset is held.
  assign reply_ready = ready_raw && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      cur_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sp_q    <= SP_W'(1);
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_POP: begin
          if (stack_empty) begin
            done_q <= 1'b1;
          end else begin
            cur_q <= mem_rd;
            sp_q  <= sp_q - SP_W'(1);
            if (target_hit) count_q <= sat_inc(count_q);
          end
        end
        ST_COLLECT: begin
          if (push_req) begin
            if (stack_full) ovf_q <= 1'b1;
            else            sp_q  <= sp_q + SP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign query_data     = cur_q;
  assign done           = done_q;
  assign path_count     = count_q;
  assign stack_overflow = ovf_q;

endmodule

// File: tb/tb_path_count_walker.sv
// Bench for path_count_walker: adjacency responder, fixed vectors, directed
// corner sequences and random DAGs checked against a path-counting model.
module tb_path_count_walker;
  localparam int NW = 10;
  localparam int CW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, sel;
  logic [NW-1:0] start_node, target_node;
  logic          query_ready, reply_valid, reply_last, reply_no_edges;
  logic [NW-1:0] reply_data;
  logic          start_a, start_b;

  logic          a_qv, a_rr, a_busy, a_done, a_ovf;
  logic [NW-1:0] a_qd;
  logic [CW-1:0] a_cnt;
  logic          b_qv, b_rr, b_busy, b_done, b_ovf;
  logic [NW-1:0] b_qd;
  logic [CW-1:0] b_cnt;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  path_count_walker #(.MAX_NODES(1024), .STACK_DEPTH(512), .COUNT_WIDTH(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .start_node(start_node), .target_node(target_node),
    .query_ready(query_ready), .query_valid(a_qv), .query_data(a_qd),
    .reply_ready(a_rr), .reply_valid(reply_valid), .reply_data(reply_data),
    .reply_last(reply_last), .reply_no_edges_found(reply_no_edges),
    .busy(a_busy), .done(a_done), .path_count(a_cnt), .stack_overflow(a_ovf));

  path_count_walker #(.MAX_NODES(1024), .STACK_DEPTH(2), .COUNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_node(start_node), .target_node(target_node),
    .query_ready(query_ready), .query_valid(b_qv), .query_data(b_qd),
    .reply_ready(b_rr), .reply_valid(reply_valid), .reply_data(reply_data),
    .reply_last(reply_last), .reply_no_edges_found(reply_no_edges),
    .busy(b_busy), .done(b_done), .path_count(b_cnt), .stack_overflow(b_ovf));

  logic          qv_s, rr_s, busy_s, done_s, ovf_s;
  logic [NW-1:0] qd_s;
  logic [CW-1:0] cnt_s;
  assign qv_s   = sel ? b_qv   : a_qv;
  assign qd_s   = sel ? b_qd   : a_qd;
  assign rr_s   = sel ? b_rr   : a_rr;
  assign busy_s = sel ? b_busy : a_busy;
  assign done_s = sel ? b_done : a_done;
  assign ovf_s  = sel ? b_ovf  : a_ovf;
  assign cnt_s  = sel ? b_cnt  : a_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int            adj_cnt [1024];
  logic [NW-1:0] adj     [1024][8];
  logic [NW-1:0] queried [$];

  bit qr_hold        = 1'b0;
  int extra_lat      = 0;
  int gap_fixed      = -1;
  bit resp_busy      = 1'b0;
  int beats_accepted = 0;
  int stale_drained  = 0;
  int qv_viol        = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_graph();
    for (int i = 0; i < 1024; i++) adj_cnt[i] = 0;
  endtask

  task automatic add_edge(input int from, input int to);
    adj[from][adj_cnt[from]] = NW'(to);
    adj_cnt[from]++;
  endtask

  // Adjacency responder: answers each query after 3+extra_lat cycles with one
  // beat per edge, or a single no-edges beat whose data is junk.
  task automatic send_reply(input logic [NW-1:0] node);
    int            nb;
    int            g;
    bit            ok;
    logic [NW-1:0] kids [8];
    nb = adj_cnt[node];
    for (int i = 0; i < nb; i++) kids[i] = adj[node][i];
    resp_busy = 1'b1;
    repeat (2 + extra_lat) @(negedge clk);
    for (int i = 0; i < ((nb == 0) ? 1 : nb); i++) begin
      reply_valid    = 1'b1;
      reply_last     = (nb == 0) || (i == nb - 1);
      reply_no_edges = (nb == 0);
      reply_data     = (nb == 0) ? NW'($urandom_range(0, 1023)) : kids[i];
      ok = 1'b0;
      for (int t = 0; t < 300 && !ok; t++) begin
        #1;
        if (rr_s) ok = 1'b1;
        else @(negedge clk);
      end
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL reply_handshake: node %0d beat %0d not accepted, reply_ready %0d, required 1", node, i, rr_s);
        break;
      end
      beats_accepted++;
      if (!busy_s) stale_drained++;
      @(negedge clk);
      reply_valid = 1'b0; reply_last = 1'b0; reply_no_edges = 1'b0;
      if (i < nb - 1) begin
        g = (gap_fixed >= 0) ? gap_fixed : $urandom_range(0, 1);
        repeat (g) @(negedge clk);
      end
    end
    reply_valid = 1'b0;
    resp_busy   = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] node;
    query_ready = 1'b0; reply_valid = 1'b0; reply_last = 1'b0;
    reply_no_edges = 1'b0; reply_data = '0;
    forever begin
      @(negedge clk);
      query_ready = qr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      #1;
      if (qv_s) begin
        node = qd_s;
        queried.push_back(node);
        @(negedge clk);
        query_ready = 1'b0;
        send_reply(node);
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if ((a_qv || b_qv) && !query_ready) qv_viol++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, done %0d, required 1", done_s);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input int s, input int t);
    @(negedge clk);
    start = 1'b1; start_node = NW'(s); target_node = NW'(t);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_walk(input bit dsel, input int s, input int t, input bit stray,
                          input logic [63:0] exp_cnt, input int exp_q, input bit exp_ovf,
                          input int exp_lat, input string tag);
    int            c;
    int            hits;
    logic [CW-1:0] cnt_at_done;
    sel = dsel;
    queried.delete();
    pulse_start(s, t);
    c = 1;
    while (!done_s && c < 20000) begin
      if (stray && c == 4 && busy_s) begin
        start = 1'b1; start_node = NW'($urandom_range(0, 1023)); target_node = NW'($urandom_range(0, 1023));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk({tag, ".done"}, 64'(done_s), 64'd1);
    if (!done_s) return;
    if (exp_lat >= 0) chk({tag, ".done_latency"}, 64'(c - 1), 64'(exp_lat));
    chk({tag, ".path_count"}, 64'(cnt_s), exp_cnt);
    chk({tag, ".queries"}, 64'(queried.size()), 64'(exp_q));
    chk({tag, ".stack_overflow"}, 64'(ovf_s), 64'(exp_ovf));
    hits = 0;
    foreach (queried[i]) if (queried[i] == NW'(t)) hits++;
    chk({tag, ".target_queried"}, 64'(hits), 64'd0);
    cnt_at_done = cnt_s;
    repeat (3) @(negedge clk);
    chk({tag, ".done_held"}, 64'(done_s), 64'd1);
    chk({tag, ".count_stable"}, 64'(cnt_s), 64'(cnt_at_done));
  endtask

  task automatic build_graph(input int gid);
    clear_graph();
    case (gid)
      0: begin add_edge(1, 2); add_edge(1, 3); add_edge(2, 4); add_edge(3, 4); end
      1: begin add_edge(5, 6); end
      2: begin add_edge(10, 11); end
      default: ;
    endcase
  endtask

  typedef struct {
    int          gid;
    int          s;
    int          t;
    logic [63:0] exp_cnt;
    int          exp_q;
    bit          exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int n, ti, base, deg, c;
    int id_of [10];
    int ch    [10][3];
    int nch   [10];
    logic [63:0] p [10];
    logic [63:0] v [10];

    vecs[0] = '{gid: 0, s: 1,  t: 4,  exp_cnt: 64'd2, exp_q: 3, exp_ovf: 1'b0, exp_lat: -1};
    vecs[1] = '{gid: 1, s: 5,  t: 5,  exp_cnt: 64'd1, exp_q: 0, exp_ovf: 1'b0, exp_lat: 2};
    vecs[2] = '{gid: 2, s: 10, t: 99, exp_cnt: 64'd0, exp_q: 2, exp_ovf: 1'b0, exp_lat: -1};

    rst = 1'b1; start = 1'b0; sel = 1'b0; start_node = '0; target_node = '0;
    clear_graph();
    repeat (3) @(negedge clk);
    chk("reset.busy",        64'(a_busy | b_busy), 64'd0);
    chk("reset.done",        64'(a_done | b_done), 64'd0);
    chk("reset.path_count",  64'(a_cnt | b_cnt),   64'd0);
    chk("reset.overflow",    64'(a_ovf | b_ovf),   64'd0);
    chk("reset.query_valid", 64'(a_qv | b_qv),     64'd0);
    chk("reset.query_data",  64'(a_qd | b_qd),     64'd0);
    chk("reset.reply_ready", 64'(a_rr | b_rr),     64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.reply_ready", 64'(a_rr), 64'd1);

    for (int i = 0; i < 3; i++) begin
      build_graph(vecs[i].gid);
      run_walk(1'b0, vecs[i].s, vecs[i].t, 1'b0, vecs[i].exp_cnt, vecs[i].exp_q,
               vecs[i].exp_ovf, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // query_ready withheld in QUERY, then a reply delayed by 5 extra cycles
    clear_graph(); add_edge(40, 41);
    sel = 1'b0; queried.delete(); qr_hold = 1'b1; extra_lat = 5;
    pulse_start(40, 41);
    c = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (a_qv || !a_busy) c++;
    end
    chk("hold.qv_low_while_not_ready", 64'(c), 64'd0);
    qr_hold = 1'b0;
    c = 0;
    while (queried.size() == 0 && c < 100) begin @(negedge clk); #3; c++; end
    chk("hold.query_seen", 64'(queried.size()), 64'd1);
    c = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #3;
      if (!a_busy || a_done || a_qv || reply_valid) c++;
    end
    chk("hold.collect_waits", 64'(c), 64'd0);
    c = 0;
    while (!a_done && c < 200) begin @(negedge clk); c++; end
    chk("hold.path_count", 64'(a_cnt), 64'd1);
    chk("hold.queries", 64'(queried.size()), 64'd1);
    extra_lat = 0;

    // shallow stack: root with 4 children keeps only 2
    clear_graph();
    add_edge(30, 31); add_edge(30, 32); add_edge(30, 33); add_edge(30, 34);
    run_walk(1'b1, 30, 31, 1'b0, 64'd1, 2, 1'b1, -1, "overflow");
    sel = 1'b0;

    // reset mid-COLLECT with a reply still streaming
    clear_graph();
    for (int k = 21; k <= 26; k++) add_edge(20, k);
    gap_fixed = 2; beats_accepted = 0; stale_drained = 0; queried.delete();
    pulse_start(20, 99);
    c = 0;
    while (beats_accepted == 0 && c < 200) begin @(negedge clk); c++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset.busy", 64'(a_busy), 64'd0);
    chk("midreset.reply_ready", 64'(a_rr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (resp_busy && c < 300) begin @(negedge clk); c++; end
    chk("midreset.responder_drained", 64'(resp_busy), 64'd0);
    chk("midreset.stale_beats_taken", 64'(stale_drained > 0), 64'd1);
    chk("midreset.stays_idle", 64'(a_busy), 64'd0);
    chk("midreset.done", 64'(a_done), 64'd0);
    gap_fixed = -1;
    build_graph(0);
    run_walk(1'b0, 1, 4, 1'b0, 64'd2, 3, 1'b0, -1, "after_reset");

    // random DAGs: edges only go to higher index, so acyclic by construction
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(4, 9);
      ti = $urandom_range(1, n - 1);
      base = $urandom_range(0, 1023);
      extra_lat = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) id_of[i] = (base + 7 * i) % 1024;
      clear_graph();
      for (int i = 0; i < n; i++) begin
        deg = 0;
        for (int j = i + 1; j < n; j++)
          if (deg < 3 && $urandom_range(0, 9) < 4) begin
            ch[i][deg] = j; deg++;
            add_edge(id_of[i], id_of[j]);
          end
        nch[i] = deg;
      end
      // paths to target and DFS query visits, solved bottom-up
      for (int i = n - 1; i >= 0; i--) begin
        if (i == ti) begin
          p[i] = 1; v[i] = 0;
        end else begin
          p[i] = 0; v[i] = 1;
          for (int k = 0; k < nch[i]; k++) begin
            p[i] += p[ch[i][k]];
            v[i] += v[ch[i][k]];
          end
        end
      end
      run_walk(1'b0, id_of[0], id_of[ti], 1'b1, p[0], int'(v[0]), 1'b0, -1, $sformatf("rand%0d", r));
    end
    extra_lat = 0;

    chk("query_valid_without_ready", 64'(qv_viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
